// File: rtl/cmip_cdc_req_tx.sv
// Source-domain side of a 4-phase req/ack CDC handshake: captures a payload, raises req_o, waits for ack.
// Optional stuck-handshake timeout is enabled by defining CMIP_CDC_REQ_TX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer in flight; accepts src_valid when synchronized ack is low
// REQ_HI | req_o high, waiting for synchronized ack to rise
// REQ_LO | req_o low, waiting for synchronized ack to fall
module cmip_cdc_req_tx #(
    parameter int DATA_W    = 32,
    parameter int SYNC_N    = 2,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done,
    output logic              to_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_N-1:0]   r_sync;
    logic                w_ack_s;
    logic                w_accept;
    logic                w_ack_rise;
    logic                r_req;
    logic                r_done;
    logic [DATA_W-1:0]   r_data;

    // ack_i is asynchronous to clk; only the last synchronizer stage is ever used.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], ack_i};
        end
    end

    assign w_ack_s   = r_sync[SYNC_N-1];
    assign src_ready = (r_state == IDLE) && !w_ack_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_rise  = 1'b0;
        case (r_state)
            IDLE: begin
                if (src_valid && src_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_ack_rise  = 1'b1;
                    w_state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // req_o, data_o and done leave the block straight from these flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req  <= 1'b0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_ack_rise;
            if (w_accept) begin
                r_req  <= 1'b1;
                r_data <= src_data;
            end else if (w_ack_rise) begin
                r_req <= 1'b0;
            end
        end
    end

    assign req_o  = r_req;
    assign data_o = r_data;
    assign done   = r_done;

`ifdef CMIP_CDC_REQ_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy;
    logic             w_enter;
    logic             w_to_set;
    logic             r_to_err;

    assign w_busy    = (r_state != IDLE);
    assign w_enter   = w_accept | w_ack_rise;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_nxt = w_enter ? '0 : (w_busy ? w_cnt_inc : r_cnt);
    // Set fires when the flag is low and the count sits at threshold, so a clear while saturated
    // shows one low cycle before the flag returns.
    assign w_to_set  = w_busy && !w_enter && (w_cnt_inc == CNT_MAX) && !r_to_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_to_set) begin
                r_to_err <= 1'b1;
            end else if (err_clr) begin
                r_to_err <= 1'b0;
            end
        end
    end

    assign to_err = r_to_err;
`else
    logic w_unused_to_cfg;

    assign w_unused_to_cfg = err_clr ^ (TO_CYCLES > 0);
    assign to_err          = 1'b0;
`endif

endmodule
